// File: rtl/scan_pkg.sv
// Shared definitions for the scan line sequencer.
//   state_t       : sequencer states (IDLE, LINE, BLANK, FRAME_END)
//   PIX_NORMAL    : pixels per line in normal counter mode
//   PIX_TEST      : pixels per line in test counter mode
//   DEF_*         : default frame geometry and line watchdog limit
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LINE      = 2'd1,
        BLANK     = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    localparam int PIX_NORMAL       = 1290;
    localparam int PIX_TEST         = 4096;

    localparam int DEF_LINES        = 1024;
    localparam int DEF_BLANK_CYCLES = 16;
    localparam int DEF_TIMEOUT      = 4100;

endpackage

// File: rtl/scan_down_counter.sv
// Loadable down-counter with zero flag.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   zero       : count == 0
module scan_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/scan_line_sequencer.sv
// Frame-level controller for the 12-bit pixel/line counter.
// Steps through LINES lines per frame, inserting BLANK_CYCLES of blanking
// between lines, and reports completion, abort and line timeout.
//
// State table
//   state     | meaning
//   IDLE      | waiting for start
//   LINE      | pixel counter enabled, waiting for end_line
//   BLANK     | inter-line blanking, pixel counter held cleared
//   FRAME_END | one-cycle frame completion, restart if cont
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame request (IDLE only)
//   stop        : graceful abort request (LINE/BLANK)
//   cont        : continuous mode, sampled in FRAME_END
//   test        : counter mode, latched at frame start
//   end_line    : end-of-line strobe from the pixel counter
//   line_enb    : pixel counter enable (LINE only)
//   test_out    : latched counter mode
//   line_idx    : current line number
//   blank       : high in BLANK
//   busy        : high outside IDLE
//   frame_done  : one-cycle pulse on frame completion
//   aborted     : one-cycle pulse when a stop completes
//   err         : sticky line timeout, cleared by the next accepted start
module scan_line_sequencer
    import scan_pkg::*;
#(
    parameter int LINES        = DEF_LINES,
    parameter int LINE_W       = 10,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int TMO_W        = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    input  logic              test,
    input  logic              end_line,
    output logic              line_enb,
    output logic              test_out,
    output logic [LINE_W-1:0] line_idx,
    output logic              blank,
    output logic              busy,
    output logic              frame_done,
    output logic              aborted,
    output logic              err
);

    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

    state_t            state, state_nx;
    logic              stop_pend, stop_pend_nx;
    logic [LINE_W-1:0] idx_nx;
    logic              test_nx, err_nx, done_nx, abort_nx;
    logic              blank_zero, wd_zero;
    logic              blank_load, wd_load;

    // Blank timer: loaded with BLANK_CYCLES-1 on LINE->BLANK, so BLANK
    // lasts exactly BLANK_CYCLES cycles.
    assign blank_load = (state == LINE) && (state_nx == BLANK);

    scan_down_counter #(.W(BLK_W)) u_blank_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blank_load),
        .load_val (BLK_W'(BLANK_CYCLES - 1)),
        .dec      (state == BLANK),
        .zero     (blank_zero)
    );

    // Line watchdog kept as cycles remaining: elapsed = TIMEOUT-1 - count.
    // Loading TIMEOUT-1 on every LINE entry is the "clear to zero"; zero
    // means the elapsed count has reached TIMEOUT-1.
    assign wd_load = (state != LINE) && (state_nx == LINE);

    scan_down_counter #(.W(TMO_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wd_load),
        .load_val (TMO_W'(TIMEOUT - 1)),
        .dec      (state == LINE),
        .zero     (wd_zero)
    );

    always_comb begin
        state_nx     = state;
        stop_pend_nx = stop_pend;
        idx_nx       = line_idx;
        test_nx      = test_out;
        err_nx       = err;
        abort_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx     = LINE;
                    idx_nx       = '0;
                    test_nx      = test;
                    err_nx       = 1'b0;
                    stop_pend_nx = 1'b0;
                end
            end
            LINE: begin
                if (end_line) begin
                    if (stop_pend || stop) begin
                        state_nx     = IDLE;
                        abort_nx     = 1'b1;
                        stop_pend_nx = 1'b0;
                    end else if (line_idx == LAST_LINE) begin
                        state_nx = FRAME_END;
                    end else begin
                        state_nx = BLANK;
                    end
                end else if (wd_zero) begin
                    state_nx     = IDLE;
                    err_nx       = 1'b1;
                    stop_pend_nx = 1'b0;
                end else if (stop) begin
                    stop_pend_nx = 1'b1;
                end
            end
            BLANK: begin
                if (stop) begin
                    state_nx = IDLE;
                    abort_nx = 1'b1;
                end else if (blank_zero) begin
                    state_nx = LINE;
                    idx_nx   = line_idx + 1'b1;
                end
            end
            FRAME_END: begin
                if (cont && !stop_pend && !stop) begin
                    state_nx = LINE;
                    idx_nx   = '0;
                    test_nx  = test;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        done_nx = (state_nx == FRAME_END);
    end

    // Outputs decoded from next state so they move on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stop_pend  <= 1'b0;
            line_idx   <= '0;
            test_out   <= 1'b0;
            err        <= 1'b0;
            line_enb   <= 1'b0;
            blank      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_nx;
            stop_pend  <= stop_pend_nx;
            line_idx   <= idx_nx;
            test_out   <= test_nx;
            err        <= err_nx;
            line_enb   <= (state_nx == LINE);
            blank      <= (state_nx == BLANK);
            busy       <= (state_nx != IDLE);
            frame_done <= done_nx;
            aborted    <= abort_nx;
        end
    end

endmodule

// File: tb/tb_scan_line_sequencer.sv
// Self-checking bench for scan_line_sequencer (LINES=4, BLANK_CYCLES=3).
// Expected outputs come from a frame timeline computed arithmetically from
// line length, blanking length and the stop/timeout rules.
module tb_scan_line_sequencer;
    import scan_pkg::*;

    localparam int LINES   = 4;
    localparam int LW      = 2;
    localparam int BLANK   = 3;
    localparam int TIMEOUT = 4100;

    logic          clk = 1'b0;
    logic          rst_n, start, stop, cont, test, end_line;
    logic          line_enb, test_out, blank, busy, frame_done, aborted, err;
    logic [LW-1:0] line_idx;

    int  checks = 0;
    int  errors = 0;
    int  pix_cnt = 0;
    bit  mute = 1'b0;

    scan_line_sequencer #(
        .LINES(LINES), .LINE_W(LW), .BLANK_CYCLES(BLANK),
        .TIMEOUT(TIMEOUT), .TMO_W(13)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .test(test), .end_line(end_line), .line_enb(line_enb),
        .test_out(test_out), .line_idx(line_idx), .blank(blank), .busy(busy),
        .frame_done(frame_done), .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;

    // Pixel counter plant: end_line after PIX enabled cycles; random
    // noise on end_line whenever the counter is disabled.
    always @(negedge clk) begin
        if (line_enb) begin
            pix_cnt  = pix_cnt + 1;
            end_line = !mute && (pix_cnt == (test_out ? PIX_TEST : PIX_NORMAL));
        end else begin
            pix_cnt  = 0;
            end_line = ($urandom_range(0, 3) == 0);
        end
    end

    function automatic logic [15:0] outs();
        return {7'b0, busy, line_enb, blank, frame_done, aborted, err, test_out, line_idx};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at #1 after the edge that accepted start. Walks the expected
    // timeline of nframes frames (or an abort at cycle abort_at) and a few
    // idle cycles, checking every cycle and randomising ignored inputs.
    task automatic watch(input string tag, input int pix, input int nframes,
                         input bit t0, input int abort_at);
        int period, flen, end_c, last_k, r, k, rr;
        bit is_fe;
        logic [15:0] exp;
        period = pix + BLANK;
        flen   = LINES*pix + (LINES-1)*BLANK + 1;
        end_c  = nframes * flen;
        last_k = LINES - 1;
        if (abort_at >= 0) begin
            last_k = abort_at / period;
            end_c  = ((abort_at % period) < pix) ? last_k*period + pix : abort_at + 1;
        end
        for (int c = 0; c < end_c + 3; c++) begin
            r     = c % flen;
            k     = r / period;
            rr    = r % period;
            is_fe = (r == flen - 1);
            if (c >= end_c)
                exp = {7'b0, 1'b0, 1'b0, 1'b0, 1'b0, (abort_at >= 0 && c == end_c), 1'b0, t0, LW'(last_k)};
            else if (is_fe)
                exp = {7'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t0, LW'(LINES-1)};
            else
                exp = {7'b0, 1'b1, (rr < pix), (rr >= pix), 1'b0, 1'b0, 1'b0, t0, LW'(k)};
            check(tag, outs(), exp);
            stop  = (c == abort_at);
            start = (c < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            test  = is_fe ? t0 : 1'($urandom_range(0, 1));
            cont  = is_fe ? ((c / flen) < nframes - 1) : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        stop = 1'b0;
    endtask

    task automatic go(input bit t);
        start = 1'b1; stop = 1'b0; test = t;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int s;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; test = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outs", outs(), 16'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_after_reset", outs(), 16'h0);
        end

        // start and stop together: stay idle
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        check("start_stop_same", outs(), 16'h0);
        start = 1'b0; stop = 1'b0;

        // single normal frame
        go(1'b0);
        watch("frame_normal", PIX_NORMAL, 1, 1'b0, -1);

        // test mode latched for the whole frame
        go(1'b1);
        watch("frame_test", PIX_TEST, 1, 1'b1, -1);

        // stop during line 2
        s = 2*(PIX_NORMAL+BLANK) + $urandom_range(0, PIX_NORMAL-1);
        go(1'b0);
        watch("stop_line2", PIX_NORMAL, 1, 1'b0, s);

        // stop during a blanking interval
        s = $urandom_range(0, 2)*(PIX_NORMAL+BLANK) + PIX_NORMAL + $urandom_range(0, BLANK-1);
        go(1'b0);
        watch("stop_blank", PIX_NORMAL, 1, 1'b0, s);

        // continuous mode, two frames
        go(1'b0);
        watch("cont_2frames", PIX_NORMAL, 2, 1'b0, -1);

        // timeout: counter never reports end of line
        mute = 1'b1;
        go(1'b0);
        for (int c = 0; c <= TIMEOUT + 1; c++) begin
            if (c < TIMEOUT)
                check("timeout_line", outs(), {7'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LW'(0)});
            else
                check("timeout_err", outs(), {7'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LW'(0)});
            @(posedge clk); #1;
        end
        mute = 1'b0;

        // next start clears err and runs normally
        go(1'b1);
        watch("after_timeout", PIX_TEST, 1, 1'b1, -1);

        // reset mid-frame
        go(1'b0);
        repeat ($urandom_range(10, 2000)) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset_midframe", outs(), 16'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_after_midreset", outs(), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
